wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameters: BUF_DEPTH, default 2, depth of the ALU holding buffer; DW, default `REG_SIZE (32), result width; AW, default `REG_ADDR (5), register-address width.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- alu_regwrite  in  1  exec1 result valid this cycle.
- alu_wreg  in  AW  exec1 destination register.
- alu_result  in  DW  exec1 result.
- alu_overflow  in  1  exec1 overflow.
- mul_regwrite  in  1  M5 result valid this cycle.
- mul_wreg  in  AW  M5 destination register.
- mul_result  in  DW  M5 result.
- mul_overflow  in  1  M5 overflow.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  AW  register-file write address, registered.
- rf_wdata  out  DW  register-file write data, registered.
- exc_overflow  out  1  one-cycle overflow exception pulse, registered.
- exc_wreg  out  AW  destination register of the faulting result.
- stall_alu  out  1  ALU producer must hold; combinational from count only.
- drop_err  out  1  sticky: ALU result lost while stall_alu was high.

Function
REQ-003 SHALL merge the exec1 and M5 result streams onto one register-file write port, one write per cycle maximum.
REQ-004 SHALL give M5 absolute priority each cycle, since the multiply pipe cannot stall.
REQ-005 SHALL, with no M5 result, select the oldest buffered ALU entry; when the buffer is empty, the incoming ALU result directly.
REQ-006 SHALL push a valid ALU input that is not selected this cycle into the tail of a FIFO of BUF_DEPTH entries, each entry holding {wreg, result, ovf}.
REQ-007 SHALL handle a simultaneous pop and push in one cycle: count unchanged, order preserved, oldest entry emitted.
REQ-008 SHALL treat any input with wreg == 0 as a non-write: never buffered, never emitted, no exception.
REQ-009 SHALL register the selected entry; rf_we/rf_waddr/rf_wdata appear the cycle after selection, so the direct-path latency is 1 cycle.
REQ-010 SHALL, when the selected entry has ovf = 1, drive rf_we = 0 and exc_overflow = 1 for one cycle, with exc_wreg = the entry's wreg.
REQ-011 SHALL hold rf_we = 0 and exc_overflow = 0 in cycles where nothing is selected; rf_waddr and rf_wdata then hold their last value.
REQ-012 SHALL drive stall_alu = 1 exactly when count == BUF_DEPTH.
REQ-013 SHALL, on alu_regwrite = 1 while stall_alu = 1, discard the input and set drop_err; drop_err stays set until reset.
REQ-014 SHALL keep the count in range 0..BUF_DEPTH, with read and write pointers wrapping modulo BUF_DEPTH.
REQ-015 SHALL perform no WAW reordering checks; decode guarantees no in-flight M5 and ALU results target the same register.
REQ-016 SHALL produce each accepted result exactly once and never emit a buffered entry twice.

Reset
REQ-017 SHALL, on reset assertion, immediately clear rf_we, rf_waddr, rf_wdata, exc_overflow, exc_wreg, drop_err, count and pointers to 0, independent of clk.
REQ-018 SHALL discard buffered entries on reset mid-operation; the first write after reset comes only from inputs sampled after deassertion.

Verification
REQ-019 Direct ALU path: alu_regwrite = 1, wreg = 3, result = 0x11, buffer empty, no mul -> next cycle rf_we = 1, waddr = 3, wdata = 0x11.
REQ-020 Collision: same cycle ALU (r4, 0xA) and M5 (r5, 0xB) -> cycle+1 write r5 = 0xB, cycle+2 write r4 = 0xA, count returns to 0.
REQ-021 Buffer full: three consecutive cycles of M5 + ALU writes -> stall_alu = 1 after the second cycle; an ALU input in the third cycle sets drop_err = 1; buffered entries later emitted in original order.
REQ-022 Overflow: M5 result r7 with mul_overflow = 1 -> next cycle rf_we = 0, exc_overflow = 1, exc_wreg = 7, for exactly one cycle.
REQ-023 r0 and reset: ALU write to r0 -> no write and no buffering; reset asserted with count = 2 -> count 0, stall_alu = 0, rf_we = 0 immediately, with no stale writes after deassertion.

Source files
------------

// File: rtl/wb_arbiter.sv
// Merges the exec1 (ALU) and M5 (multiply) result streams onto one register-file write port.
// M5 always wins the slot; displaced ALU results wait in a small FIFO.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef REG_ADDR
`define REG_ADDR 5
`endif

module wb_arbiter #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned DW        = `REG_SIZE,
  parameter int unsigned AW        = `REG_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_regwrite,
  input  logic [AW-1:0] alu_wreg,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_overflow,
  input  logic          mul_regwrite,
  input  logic [AW-1:0] mul_wreg,
  input  logic [DW-1:0] mul_result,
  input  logic          mul_overflow,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          exc_overflow,
  output logic [AW-1:0] exc_wreg,
  output logic          stall_alu,
  output logic          drop_err
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(BUF_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(BUF_DEPTH - 1);

  logic [AW-1:0] buf_wreg_q   [BUF_DEPTH];
  logic [DW-1:0] buf_result_q [BUF_DEPTH];
  logic          buf_ovf_q    [BUF_DEPTH];

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          exc_q, exc_d;
  logic [AW-1:0] exc_wreg_q, exc_wreg_d;
  logic          drop_q, drop_d;

  logic          mul_valid, alu_valid, push, pop;
  logic          sel_valid, sel_ovf;
  logic [AW-1:0] sel_wreg;
  logic [DW-1:0] sel_result;

  assign stall_alu = (count_q == CntFull);
  // Writes to r0 are not writes at all: they never occupy the slot or the buffer.
  assign mul_valid = mul_regwrite && (mul_wreg != '0);
  assign alu_valid = alu_regwrite && (alu_wreg != '0) && !stall_alu;

  always_comb begin
    sel_valid  = 1'b0;
    sel_wreg   = mul_wreg;
    sel_result = mul_result;
    sel_ovf    = mul_overflow;
    push       = 1'b0;
    pop        = 1'b0;
    if (mul_valid) begin
      sel_valid = 1'b1;
      push      = alu_valid;
    end else if (count_q != '0) begin
      sel_valid  = 1'b1;
      sel_wreg   = buf_wreg_q[rd_ptr_q];
      sel_result = buf_result_q[rd_ptr_q];
      sel_ovf    = buf_ovf_q[rd_ptr_q];
      pop        = 1'b1;
      push       = alu_valid;
    end else if (alu_valid) begin
      sel_valid  = 1'b1;
      sel_wreg   = alu_wreg;
      sel_result = alu_result;
      sel_ovf    = alu_overflow;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
  end

  always_comb begin
    rf_we_d    = sel_valid && !sel_ovf;
    exc_d      = sel_valid && sel_ovf;
    rf_waddr_d = rf_we_d ? sel_wreg : rf_waddr_q;
    rf_wdata_d = rf_we_d ? sel_result : rf_wdata_q;
    exc_wreg_d = exc_d ? sel_wreg : exc_wreg_q;
    drop_d     = drop_q || (alu_regwrite && stall_alu);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      exc_q      <= 1'b0;
      exc_wreg_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      exc_q      <= exc_d;
      exc_wreg_q <= exc_wreg_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_wreg_q[wr_ptr_q]   <= alu_wreg;
      buf_result_q[wr_ptr_q] <= alu_result;
      buf_ovf_q[wr_ptr_q]    <= alu_overflow;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign exc_overflow = exc_q;
  assign exc_wreg     = exc_wreg_q;
  assign drop_err     = drop_q;

endmodule
